btn_led_debounce: RTL and testbench
===================================

# btn_led_debounce

Multi-channel push-button front end that turns raw, bouncing board buttons into clean LED control. Each channel synchronises its button into the system clock domain and debounces it with a cycle counter. Per channel, it then either toggles its LED on each debounced press or makes the LED follow the button. It sits directly between the board button pins and the LED pins on the iCE40 evaluation boards and supersedes the single-channel, unclocked button-toggles-LED logic.

## Interface
- `N_CH`, default 4: number of button/LED channels (≥1).
- `DEBOUNCE_CYCLES`, default 12000: consecutive stable cycles required to accept a level change (1 ms at 12 MHz); must be ≥1.
- `BTN_ACTIVE_LOW`, default 0: 1 means a pressed button reads 0 at the pin.

Ports:
- `clk` input 1: system clock, all logic on rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `btn_i` input N_CH: raw asynchronous button pins.
- `mode_i` input N_CH: per-channel mode. 0 is TOGGLE, 1 is MOMENTARY. Synchronous, quasi-static.
- `led_o` output N_CH: LED drive, registered.
- `press_o` output N_CH: one-cycle pulse per accepted press, registered.

## Operation
- Polarity: the pin is inverted when `BTN_ACTIVE_LOW`=1, so internal "pressed" is always 1.
- Synchroniser: two flops per channel. The second flop is the synchronised level `s`.
- Debounce per channel:
  - Holds `stable` and a counter `cnt` of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - Each cycle where `s == stable`: `cnt` ← 0.
  - Each cycle where `s != stable` and `cnt == DEBOUNCE_CYCLES-1`: `stable` ← `s` and `cnt` ← 0.
  - Otherwise, each cycle where `s != stable`: `cnt` ← `cnt`+1.
  - A glitch shorter than `DEBOUNCE_CYCLES` consecutive mismatching cycles is discarded.
- Press event: `stable` goes 0→1. `press_o` is 1 for exactly one cycle, asserted on the same edge `stable` rises. A release generates no pulse.
- TOGGLE mode: on a press event, `led_o` ← ~`led_o`. Releases have no effect.
- MOMENTARY mode: `led_o` ← `stable` every cycle.
- Mode change: switching MOMENTARY→TOGGLE keeps the current `led_o` value. Switching TOGGLE→MOMENTARY makes `led_o` equal `stable` on the next edge.
- Channels are fully independent. Simultaneous presses on several channels each pulse and toggle in the same cycle.

## Timing
- Reset values: `led_o`=0, `press_o`=0. All synchroniser flops, `stable` and `cnt` are reset to 0 (not pressed).
- Reset is asynchronous on assertion. Logic resumes on the first rising edge after `rst_n` goes high.
- Latency, with edge 0 being the first edge sampling a new held pin level:
  - `s` changes after edge 1.
  - `stable`, `led_o` and `press_o` change on edge `DEBOUNCE_CYCLES`+1.
- Minimum press-to-press spacing is `DEBOUNCE_CYCLES`+1 cycles per level change.
- Reset mid-bounce or mid-count clears all state. A button still held at reset release is seen as a new press after `DEBOUNCE_CYCLES`+2 edges.
- `DEBOUNCE_CYCLES`=1: a level change is accepted after one mismatching cycle, for a latency of 2 edges.

## Structure
- Package `btn_led_pkg` holds:
  - `MODE_TOGGLE`=1'b0 and `MODE_MOMENTARY`=1'b1.
  - `DEBOUNCE_CYCLES_DEFAULT`=12000.
- Sub-module `btn_debounce`, one per channel:
  - Parameters: `DEBOUNCE_CYCLES`.
  - Ports: `clk`, `rst_n`, `btn_i` (polarity-corrected), `level_o` (= `stable`), `rise_o` (press pulse).
  - Contains the synchroniser, counter and edge detect.
- The top level:
  - Applies polarity.
  - Generates `N_CH` `btn_debounce` instances.
  - Holds the per-channel LED/mode register logic.

## Test plan
Bench uses `N_CH`=4, `DEBOUNCE_CYCLES`=4, `BTN_ACTIVE_LOW`=0 unless stated.
- Clean press, TOGGLE: `btn_i[0]` 0→1 held for 20 cycles, then released, twice → `press_o[0]` pulses once per press, 6 edges after the rise. `led_o[0]` goes 0→1, then 1→0. No pulse on release.
- Bounce rejection: `btn_i[1]` toggles 1,0,1,0 with 3-cycle highs, then is held high → no pulse during the bounce. Exactly one pulse and one toggle 6 edges after the final rise.
- MOMENTARY: `mode_i[2]`=1, button held 10 cycles → `led_o[2]` rises 6 edges after the press and falls 6 edges after the release. Exactly one `press_o` pulse.
- Simultaneous and mode switch:
  - All four buttons are pressed on the same edge, with `led_o[3]` already 1 → all `press_o` bits pulse in the same cycle and `led_o[3]` goes to 0.
  - `mode_i[3]` is then switched 0→1 while the button is held → `led_o[3]` goes to 1 on the next edge.
- Reset mid-count: `rst_n` is pulsed low for 1 cycle 2 edges into a held press → `led_o`=0 and `press_o`=0 immediately. The press is accepted 6 edges after `rst_n` rises.
- Active-low build: `BTN_ACTIVE_LOW`=1, pins idle at 1, pin driven to 0 → behaviour identical to the clean-press scenario.

Source files
------------

// File: rtl/btn_led_pkg.sv
// Shared constants and helpers for the multi-channel button/LED front end.
package btn_led_pkg;

  localparam logic MODE_TOGGLE    = 1'b0;
  localparam logic MODE_MOMENTARY = 1'b1;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 12000;

  // Maps a raw pin level to the internal "pressed" sense (1 = pressed).
  function automatic logic pressed_level(input logic pin, input logic active_low);
    return active_low ? ~pin : pin;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, stable-count debouncer and press detect.
// level_next_o exposes the value stable takes on the coming edge so LED logic can track it without lag.
module btn_debounce
  import btn_led_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic level_o,
  output logic level_next_o,
  output logic rise_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_r;
  logic             stable_r;
  logic [CNT_W-1:0] cnt_r;
  logic             rise_r;

  logic             stable_next_s;
  logic [CNT_W-1:0] cnt_next_s;
  logic             rise_next_s;

  // Debounce next-state: accept a new level only after a full run of mismatching cycles.
  always_comb begin
    stable_next_s = stable_r;
    cnt_next_s    = cnt_r;
    if (sync_r[1] == stable_r) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (cnt_r == CNT_LAST) begin
      stable_next_s = sync_r[1];
      cnt_next_s    = {CNT_W{1'b0}};
    end else begin
      cnt_next_s = cnt_r + CNT_W'(1);
    end
    rise_next_s = ~stable_r & stable_next_s;
  end

  // Synchroniser, debounce state and registered press pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r   <= 2'b00;
      stable_r <= 1'b0;
      cnt_r    <= {CNT_W{1'b0}};
      rise_r   <= 1'b0;
    end else begin
      sync_r   <= {sync_r[0], btn_i};
      stable_r <= stable_next_s;
      cnt_r    <= cnt_next_s;
      rise_r   <= rise_next_s;
    end
  end

  assign level_o      = stable_r;
  assign level_next_o = stable_next_s;
  assign rise_o       = rise_r;

endmodule

// File: rtl/btn_led_debounce.sv
// Multi-channel button front end: polarity fix, per-channel debounce, and
// LED toggle/momentary control with a registered one-cycle press pulse.
module btn_led_debounce
  import btn_led_pkg::*;
#(
  parameter int N_CH            = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_i,
  input  logic [N_CH-1:0] mode_i,
  output logic [N_CH-1:0] led_o,
  output logic [N_CH-1:0] press_o
);

  logic [N_CH-1:0] btn_pol_s;
  logic [N_CH-1:0] level_s;
  logic [N_CH-1:0] level_next_s;
  logic [N_CH-1:0] rise_s;
  logic [N_CH-1:0] led_next_s;
  logic [N_CH-1:0] led_r;

  // Bring every pin to the "1 = pressed" sense.
  always_comb begin
    btn_pol_s = {N_CH{1'b0}};
    for (int ch = 0; ch < N_CH; ch++) begin
      btn_pol_s[ch] = pressed_level(btn_i[ch], BTN_ACTIVE_LOW);
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_deb (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_i       (btn_pol_s[g]),
      .level_o     (level_s[g]),
      .level_next_o(level_next_s[g]),
      .rise_o      (rise_s[g])
    );
  end

  // LED next state: a press edge is the stable level rising on this very edge.
  always_comb begin
    led_next_s = led_r;
    for (int ch = 0; ch < N_CH; ch++) begin
      if (mode_i[ch] == MODE_MOMENTARY) begin
        led_next_s[ch] = level_next_s[ch];
      end else if (~level_s[ch] & level_next_s[ch]) begin
        led_next_s[ch] = ~led_r[ch];
      end else begin
        led_next_s[ch] = led_r[ch];
      end
    end
  end

  // LED register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_r <= {N_CH{1'b0}};
    end else begin
      led_r <= led_next_s;
    end
  end

  assign led_o   = led_r;
  assign press_o = rise_s;

endmodule

// File: tb/tb_btn_led_debounce.sv
// Randomised plus directed bench for btn_led_debounce, checked every cycle against
// a sliding-window debounce model; an active-low copy sees inverted pins.
module tb_btn_led_debounce;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] btn = 4'b0000;
  logic [3:0] mode = 4'b0000;
  logic [3:0] btn_al;
  logic [3:0] led, press, led_al, press_al;

  int checks = 0;
  int failures = 0;

  assign btn_al = ~btn;

  always #5 clk = ~clk;

  btn_led_debounce #(.N_CH(4), .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .btn_i(btn), .mode_i(mode), .led_o(led), .press_o(press)
  );

  btn_led_debounce #(.N_CH(4), .DEBOUNCE_CYCLES(D), .BTN_ACTIVE_LOW(1'b1)) dut_al (
    .clk(clk), .rst_n(rst_n), .btn_i(btn_al), .mode_i(mode), .led_o(led_al), .press_o(press_al)
  );

  // Model: hist[c][k] is the pin sampled k+1 edges ago. The level seen by the
  // debouncer on this edge is two samples old; a change is accepted once the
  // last D of those seen levels all differ from the accepted level.
  logic [D:0] hist [4];
  logic [3:0] m_stable, m_led, m_press;
  bit         all_diff, ns;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_stable = 4'b0000;
      m_led    = 4'b0000;
      m_press  = 4'b0000;
      for (int c = 0; c < 4; c++) hist[c] = '0;
    end else begin
      for (int c = 0; c < 4; c++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= D; k++) begin
          if (hist[c][k] == m_stable[c]) all_diff = 1'b0;
        end
        ns = all_diff ? ~m_stable[c] : m_stable[c];
        m_press[c] = ~m_stable[c] & ns;
        if (mode[c]) m_led[c] = ns;
        else if (m_press[c]) m_led[c] = ~m_led[c];
        m_stable[c] = ns;
        hist[c] = {hist[c][D-1:0], btn[c]};
      end
    end
  end

  always @(negedge clk) begin
    checks = checks + 4;
    if (led !== m_led) begin
      failures++;
      $display("FAIL model_led t=%0t got=%b expected=%b", $time, led, m_led);
    end
    if (press !== m_press) begin
      failures++;
      $display("FAIL model_press t=%0t got=%b expected=%b", $time, press, m_press);
    end
    if (led_al !== m_led) begin
      failures++;
      $display("FAIL model_led_al t=%0t got=%b expected=%b", $time, led_al, m_led);
    end
    if (press_al !== m_press) begin
      failures++;
      $display("FAIL model_press_al t=%0t got=%b expected=%b", $time, press_al, m_press);
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t got=%b expected=%b", name, $time, act, exp);
    end
  endtask

  initial begin
    step(3);
    chk("reset_led", led, 4'b0000);
    chk("reset_press", press, 4'b0000);
    chk("reset_led_al", led_al, 4'b0000);
    rst_n = 1'b1;
    step(2);

    // Clean press, toggle mode, twice.
    btn[0] = 1'b1;
    step(5); chk("c0_no_pulse_early", press, 4'b0000);
    step(1); chk("c0_pulse", press, 4'b0001); chk("c0_led_on", led, 4'b0001);
    chk("c0_pulse_al", press_al, 4'b0001);
    step(1); chk("c0_pulse_one_cycle", press, 4'b0000);
    step(13); btn[0] = 1'b0;
    step(20); chk("c0_release_keeps_led", led, 4'b0001);
    btn[0] = 1'b1;
    step(6); chk("c0_pulse2", press, 4'b0001); chk("c0_led_off", led, 4'b0000);
    step(14); btn[0] = 1'b0;
    step(20);

    // Bounce rejection on channel 1.
    btn[1] = 1'b1; step(3); btn[1] = 1'b0; step(3);
    btn[1] = 1'b1; step(3); btn[1] = 1'b0; step(3);
    btn[1] = 1'b1;
    step(5); chk("c1_no_pulse_early", press, 4'b0000);
    step(1); chk("c1_pulse", press, 4'b0010); chk("c1_led", led, 4'b0010);
    step(15); btn[1] = 1'b0;
    step(20);

    // Momentary on channel 2.
    mode[2] = 1'b1; step(2);
    btn[2] = 1'b1;
    step(5); chk("c2_led_before", led, 4'b0010);
    step(1); chk("c2_led_on", led, 4'b0110); chk("c2_pulse", press, 4'b0100);
    step(4); btn[2] = 1'b0;
    step(5); chk("c2_led_held", led, 4'b0110);
    step(1); chk("c2_led_off", led, 4'b0010);
    step(10);

    // Set led[3], then simultaneous press and a toggle->momentary switch.
    btn[3] = 1'b1; step(6); chk("c3_led_on", led, 4'b1010);
    step(10); btn[3] = 1'b0; step(10);
    btn = 4'b1111;
    step(6); chk("all_pulse", press, 4'b1111); chk("all_led", led, 4'b0101);
    mode[3] = 1'b1;
    step(1); chk("mode_switch_led", led, 4'b1101);
    step(5); btn = 4'b0000; step(12);

    // Reset in the middle of a held press count.
    mode = 4'b0000; step(2);
    btn[0] = 1'b1; step(2);
    #2 rst_n = 1'b0;
    #1 chk("rst_led", led, 4'b0000); chk("rst_press", press, 4'b0000);
    @(negedge clk); #2 rst_n = 1'b1;
    step(5); chk("rst_no_pulse_early", press, 4'b0000);
    step(1); chk("rst_pulse", press, 4'b0001); chk("rst_led_on", led, 4'b0001);
    step(10); btn[0] = 1'b0; step(10);

    // Random phase: bouncy pins, occasional mode flips and resets.
    for (int i = 0; i < 4000; i++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(5, 0) == 0) btn[c] = ~btn[c];
        if ($urandom_range(199, 0) == 0) mode[c] = ~mode[c];
      end
      if ($urandom_range(999, 0) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
      end else begin
        step(1);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
